fp_sub_pipe: RTL and testbench

//  Pipelined fixed-point subtractor c = a - b; the subtracting counterpart of fp_add.

---
 rtl/fp_sub_pipe_if.sv | 29 ++
 rtl/fp_sub_pipe.sv | 138 +++++++++++++
 tb/tb_fp_sub_pipe.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_sub_pipe_if.sv
// Operand/result stream bundle for fp_sub_pipe: valid/ready on both the input and result sides.
interface fp_sub_pipe_if #(
    parameter int W1 = 16,
    parameter int W2 = 16,
    parameter int W3 = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [W1-1:0] a;
    logic          s1;
    logic [W2-1:0] b;
    logic          s2;
    logic          out_valid;
    logic          out_ready;
    logic [W3-1:0] c;
    logic          c_signed;
    logic          overflow;
    logic          underflow;

    modport master (
        output in_valid, a, s1, b, s2, out_ready,
        input  in_ready, out_valid, c, c_signed, overflow, underflow
    );

    modport slave (
        input  in_valid, a, s1, b, s2, out_ready,
        output in_ready, out_valid, c, c_signed, overflow, underflow
    );
endinterface

// File: rtl/fp_sub_pipe.sv
// Two-stage pipelined fixed-point subtractor c = a - b with saturating requantisation to Qi3.f3.
// Optional macro FP_SUB_ROUND_EN: round half-up when fraction bits are dropped (default floor).
module fp_sub_pipe #(
    parameter int i1 = 2,
    parameter int f1 = 14,
    parameter int i2 = 2,
    parameter int f2 = 14,
    parameter int i3 = 2,
    parameter int f3 = 14
) (
    input  logic         clk,
    input  logic         rst,
    fp_sub_pipe_if.slave bus,
    input  logic         clr_flags,
    output logic         ovf_sticky,
    output logic         unf_sticky
);
    localparam int F    = (f1 > f2) ? f1 : f2;
    localparam int I    = ((i1 > i2) ? i1 : i2) + 2;
    localparam int W    = I + F;
    localparam int WA   = i1 + f1;
    localparam int WB   = i2 + f2;
    localparam int W3   = i3 + f3;
    localparam int DROP = (F > f3) ? F - f3 : 0;
    localparam int UP   = (f3 > F) ? f3 - F : 0;
    // Wide enough for the shifted difference and for the unsigned max bound as a positive value
    localparam int QW   = (W + UP + 1 > W3 + 2) ? W + UP + 1 : W3 + 2;
    localparam logic signed [QW-1:0] ONE = {{(QW-1){1'b0}}, 1'b1};
`ifdef FP_SUB_ROUND_EN
    localparam int RND = (DROP > 0) ? DROP - 1 : 0;
    localparam logic signed [QW-1:0] RND_ADD = (DROP > 0) ? (ONE <<< RND) : {QW{1'b0}};
`endif

    logic                 en_s;
    logic signed [W-1:0]  ta_s, tb_s, ta_r, tb_r, diff_s;
    logic                 v1_r, sres_r;
    logic signed [QW-1:0] q_s, max_s, min_s;
    logic [W3-1:0]        c_s, c_r;
    logic                 ovf_s, unf_s;
    logic                 out_valid_r, c_signed_r, ovf_r, unf_r;
    logic                 ovf_sticky_r, unf_sticky_r;

    assign en_s          = !out_valid_r | bus.out_ready;
    assign bus.in_ready  = en_s;
    assign bus.out_valid = out_valid_r;
    assign bus.c         = c_r;
    assign bus.c_signed  = c_signed_r;
    assign bus.overflow  = ovf_r;
    assign bus.underflow = unf_r;
    assign ovf_sticky    = ovf_sticky_r;
    assign unf_sticky    = unf_sticky_r;

    // Align both operands to a common Q(I).F grid; the extension bit is the sign only when signed
    always_comb begin
        ta_s = {{(W-WA){bus.s1 & bus.a[WA-1]}}, bus.a} << (F - f1);
        tb_s = {{(W-WB){bus.s2 & bus.b[WB-1]}}, bus.b} << (F - f2);
    end

    // Exact difference, requantise to f3 fraction bits, then clamp to the result range
    always_comb begin
        diff_s = ta_r - tb_r;
        q_s    = {{(QW-W){diff_s[W-1]}}, diff_s};
`ifdef FP_SUB_ROUND_EN
        q_s    = q_s + RND_ADD;
`endif
        q_s    = (q_s >>> DROP) <<< UP;
        if (sres_r) begin
            max_s = (ONE <<< (W3 - 1)) - ONE;
            min_s = -(ONE <<< (W3 - 1));
        end else begin
            max_s = (ONE <<< W3) - ONE;
            min_s = {QW{1'b0}};
        end
        c_s   = q_s[W3-1:0];
        ovf_s = 1'b0;
        unf_s = 1'b0;
        if (q_s > max_s) begin
            c_s   = max_s[W3-1:0];
            ovf_s = 1'b1;
        end else if (q_s < min_s) begin
            c_s   = min_s[W3-1:0];
            unf_s = 1'b1;
        end else begin
            c_s   = q_s[W3-1:0];
        end
    end

    // Stage 1 registers: aligned operands, result signedness and valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r   <= 1'b0;
            ta_r   <= {W{1'b0}};
            tb_r   <= {W{1'b0}};
            sres_r <= 1'b0;
        end else if (en_s) begin
            v1_r   <= bus.in_valid;
            ta_r   <= ta_s;
            tb_r   <= tb_s;
            sres_r <= bus.s1 | bus.s2;
        end
    end

    // Stage 2 registers: the presented result, held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            c_r         <= {W3{1'b0}};
            c_signed_r  <= 1'b0;
            ovf_r       <= 1'b0;
            unf_r       <= 1'b0;
        end else if (en_s) begin
            out_valid_r <= v1_r;
            c_r         <= c_s;
            c_signed_r  <= sres_r;
            ovf_r       <= ovf_s;
            unf_r       <= unf_s;
        end
    end

    // Sticky flags; a flagged result taken in the same cycle as a clear keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky_r <= 1'b0;
            unf_sticky_r <= 1'b0;
        end else begin
            if (out_valid_r & bus.out_ready & ovf_r) begin
                ovf_sticky_r <= 1'b1;
            end else if (clr_flags) begin
                ovf_sticky_r <= 1'b0;
            end
            if (out_valid_r & bus.out_ready & unf_r) begin
                unf_sticky_r <= 1'b1;
            end else if (clr_flags) begin
                unf_sticky_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fp_sub_pipe.sv
// Self-checking bench for fp_sub_pipe: spec vectors, stall/reset sequences and random traffic vs a value model.
`timescale 1ns/1ps
module tb_fp_sub_pipe;
    localparam int F1 = 14, F2 = 14;
    localparam int F3A = 14, W3A = 16;
    localparam int F3B = 13, W3B = 15;

    typedef struct packed {
        logic [15:0] a;
        logic        s1;
        logic [15:0] b;
        logic        s2;
    } op_t;

    typedef struct {
        op_t         op;
        logic [15:0] c;
        logic        cs, ov, un;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic clr_flags;
    logic ovf0, unf0, ovf1, unf1;
    int   n_vec = 0, n_bad = 0, n_pop = 0;

    fp_sub_pipe_if #(.W1(16), .W2(16), .W3(W3A)) bus0 ();
    fp_sub_pipe_if #(.W1(16), .W2(16), .W3(W3B)) bus1 ();

    fp_sub_pipe #(.i1(2), .f1(14), .i2(2), .f2(14), .i3(2), .f3(F3A)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .clr_flags(clr_flags),
        .ovf_sticky(ovf0), .unf_sticky(unf0));
    fp_sub_pipe #(.i1(2), .f1(14), .i2(2), .f2(14), .i3(2), .f3(F3B)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .clr_flags(clr_flags),
        .ovf_sticky(ovf1), .unf_sticky(unf1));

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: expected event did not occur by %0t", nm, $time);
    endfunction

    function automatic op_t mkop(input logic [15:0] a, input logic s1, input logic [15:0] b, input logic s2);
        op_t o;
        o.a = a; o.s1 = s1; o.b = b; o.s2 = s2;
        return o;
    endfunction

    function automatic vec_t mkv(input op_t op, input logic [15:0] c, input logic cs, input logic ov, input logic un);
        vec_t v;
        v.op = op; v.c = c; v.cs = cs; v.ov = ov; v.un = un;
        return v;
    endfunction

    function automatic op_t rand_op();
        return mkop(16'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
    endfunction

    // Value model: operands as integers in units of 2^-F, divide/multiply to 2^-f3, clamp
    function automatic void model(input op_t op, input int f3, input int w3,
                                  output logic [15:0] c, output logic cs, output logic ov, output logic un);
        longint av, bv, d, q, m, mx, mn;
        int     fm;
        fm = (F1 > F2) ? F1 : F2;
        if (op.s1) av = longint'($signed(op.a)); else av = longint'(op.a);
        if (op.s2) bv = longint'($signed(op.b)); else bv = longint'(op.b);
        av = av * (longint'(1) << (fm - F1));
        bv = bv * (longint'(1) << (fm - F2));
        d  = av - bv;
        if (fm > f3) begin
            m = longint'(1) << (fm - f3);
`ifdef FP_SUB_ROUND_EN
            d = d + m / 2;
`endif
            q = d / m;
            if ((d % m != 0) && (d < 0)) q = q - 1;
        end else begin
            q = d * (longint'(1) << (f3 - fm));
        end
        cs = op.s1 | op.s2;
        if (cs) begin
            mx = (longint'(1) << (w3 - 1)) - 1;
            mn = -(longint'(1) << (w3 - 1));
        end else begin
            mx = (longint'(1) << w3) - 1;
            mn = 0;
        end
        ov = 1'b0;
        un = 1'b0;
        if (q > mx) begin q = mx; ov = 1'b1; end
        else if (q < mn) begin q = mn; un = 1'b1; end
        c = 16'(q & ((longint'(1) << w3) - 1));
    endfunction

    task automatic drive(input op_t op, input logic v);
        bus0.in_valid = v; bus0.a = op.a; bus0.s1 = op.s1; bus0.b = op.b; bus0.s2 = op.s2;
        bus1.in_valid = v; bus1.a = op.a; bus1.s1 = op.s1; bus1.b = op.b; bus1.s2 = op.s2;
    endtask

    task automatic set_ordy(input logic r);
        bus0.out_ready = r;
        bus1.out_ready = r;
    endtask

    task automatic send(input op_t op);
        int t;
        drive(op, 1'b1);
        t = 0;
        @(negedge clk);
        while (!bus0.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!bus0.in_ready) fail("send_timeout");
        @(posedge clk); #1;
        drive(op, 1'b0);
    endtask

    // Single transaction into an empty pipe: nothing after 1 edge, result after 2, then drained
    task automatic apply_check(input string nm, input vec_t v);
        drive(v.op, 1'b1);
        @(posedge clk); #1;
        drive(v.op, 1'b0);
        @(negedge clk);
        chk({nm, "_early"}, 32'(bus0.out_valid), 32'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 32'(bus0.out_valid), 32'd1);
        chk({nm, "_c"}, 32'(bus0.c), 32'(v.c));
        chk({nm, "_csigned"}, 32'(bus0.c_signed), 32'(v.cs));
        chk({nm, "_ovf"}, 32'(bus0.overflow), 32'(v.ov));
        chk({nm, "_unf"}, 32'(bus0.underflow), 32'(v.un));
        @(posedge clk); #1;
    endtask

    // Scoreboard monitor: records accepted operands, checks presented results and sticky flags
    op_t         q_in[$];
    op_t         mon_op;
    logic [15:0] e_c;
    logic        e_cs, e_ov, e_un;
    logic        so0 = 1'b0, su0 = 1'b0, so1 = 1'b0, su1 = 1'b0;
    logic        nso0, nsu0, nso1, nsu1;

    always @(negedge clk) begin
        if (rst) begin
            q_in.delete();
            so0 = 1'b0; su0 = 1'b0; so1 = 1'b0; su1 = 1'b0;
            chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
            chk("rst_c", 32'(bus0.c), 32'd0);
            chk("rst_flags", 32'({bus0.c_signed, bus0.overflow, bus0.underflow, ovf0, unf0}), 32'd0);
            chk("rst_in_ready", 32'(bus0.in_ready), 32'd1);
            chk("rst_out_valid_b", 32'(bus1.out_valid), 32'd0);
        end else begin
            chk("ovf_sticky0", 32'(ovf0), 32'(so0));
            chk("unf_sticky0", 32'(unf0), 32'(su0));
            chk("ovf_sticky1", 32'(ovf1), 32'(so1));
            chk("unf_sticky1", 32'(unf1), 32'(su1));
            nso0 = so0 & !clr_flags; nsu0 = su0 & !clr_flags;
            nso1 = so1 & !clr_flags; nsu1 = su1 & !clr_flags;
            if (bus0.out_valid && bus0.out_ready) begin
                if (q_in.size() == 0) begin
                    fail("spurious_result");
                end else begin
                    mon_op = q_in.pop_front();
                    n_pop++;
                    model(mon_op, F3A, W3A, e_c, e_cs, e_ov, e_un);
                    chk("sb_c", 32'(bus0.c), 32'(e_c));
                    chk("sb_csigned", 32'(bus0.c_signed), 32'(e_cs));
                    chk("sb_flags", 32'({bus0.overflow, bus0.underflow}), 32'({e_ov, e_un}));
                    nso0 = nso0 | e_ov; nsu0 = nsu0 | e_un;
                    model(mon_op, F3B, W3B, e_c, e_cs, e_ov, e_un);
                    chk("sb13_valid", 32'(bus1.out_valid), 32'd1);
                    chk("sb13_c", 32'(bus1.c), 32'(e_c));
                    chk("sb13_flags", 32'({bus1.overflow, bus1.underflow}), 32'({e_ov, e_un}));
                    nso1 = nso1 | e_ov; nsu1 = nsu1 | e_un;
                end
            end
            if (bus0.in_valid && bus0.in_ready)
                q_in.push_back(mkop(bus0.a, bus0.s1, bus0.b, bus0.s2));
            so0 = nso0; su0 = nsu0; so1 = nso1; su1 = nsu1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[7];
        op_t         ops[4];
        int          p0;
        logic [15:0] held, e6;
        bit          seen;

        tbl[0] = mkv(mkop(16'h4000, 1'b0, 16'h2000, 1'b0), 16'h2000, 1'b0, 1'b0, 1'b0);
        tbl[1] = mkv(mkop(16'h2000, 1'b0, 16'h4000, 1'b0), 16'h0000, 1'b0, 1'b0, 1'b1);
        tbl[2] = mkv(mkop(16'h7FFF, 1'b1, 16'hC000, 1'b1), 16'h7FFF, 1'b1, 1'b1, 1'b0);
        tbl[3] = mkv(mkop(16'h8000, 1'b1, 16'h4000, 1'b1), 16'h8000, 1'b1, 1'b0, 1'b1);
        tbl[4] = mkv(mkop(16'hFFFF, 1'b0, 16'hFFFF, 1'b1), 16'h7FFF, 1'b1, 1'b1, 1'b0);
        tbl[5] = mkv(mkop(16'hC000, 1'b1, 16'h0000, 1'b0), 16'hC000, 1'b1, 1'b0, 1'b0);
        tbl[6] = mkv(mkop(16'hFFFF, 1'b0, 16'h0000, 1'b0), 16'hFFFF, 1'b0, 1'b0, 1'b0);

        rst = 1'b1;
        clr_flags = 1'b0;
        drive(mkop(16'h0000, 1'b0, 16'h0000, 1'b0), 1'b0);
        set_ordy(1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int k = 0; k < 7; k++) apply_check($sformatf("vec%0d", k), tbl[k]);

        @(negedge clk);
        chk("ovf_sticky_held", 32'(ovf0), 32'd1);
        chk("unf_sticky_held", 32'(unf0), 32'd1);
        @(posedge clk); #1 clr_flags = 1'b1;
        @(posedge clk); #1 clr_flags = 1'b0;
        @(negedge clk);
        chk("sticky_cleared", 32'({ovf0, unf0}), 32'd0);
        @(posedge clk); #1;

        // Dropping one fraction bit of 2^-14: floor gives 0, half-up gives 1
`ifdef FP_SUB_ROUND_EN
        e6 = 16'h0001;
`else
        e6 = 16'h0000;
`endif
        drive(mkop(16'h0001, 1'b0, 16'h0000, 1'b0), 1'b1);
        @(posedge clk); #1;
        drive(mkop(16'h0001, 1'b0, 16'h0000, 1'b0), 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("q13_valid", 32'(bus1.out_valid), 32'd1);
        chk("q13_c", 32'(bus1.c), 32'(e6));
        @(posedge clk); #1;

        for (int k = 0; k < 4; k++) ops[k] = rand_op();
        p0 = n_pop;
        fork
            for (int k = 0; k < 4; k++) send(ops[k]);
            begin
                seen = 1'b0;
                for (int t = 0; t < 20 && !seen; t++) begin
                    @(posedge clk); #1;
                    if (bus0.out_valid) seen = 1'b1;
                end
                if (!seen) fail("stall_wait");
                set_ordy(1'b0);
                held = bus0.c;
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_c", 32'(bus0.c), 32'(held));
                    chk("stall_in_ready", 32'(bus0.in_ready), 32'd0);
                    chk("stall_valid", 32'(bus0.out_valid), 32'd1);
                end
                @(posedge clk); #1;
                set_ordy(1'b1);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("stall_count", 32'(n_pop - p0), 32'd4);
        chk("stall_empty", 32'(q_in.size()), 32'd0);

        send(rand_op());
        send(rand_op());
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", 32'(bus0.out_valid), 32'd0);
        chk("midrst_c", 32'(bus0.c), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        apply_check("post_rst", mkv(mkop(16'h4000, 1'b0, 16'h1000, 1'b0), 16'h3000, 1'b0, 1'b0, 1'b0));
        chk("post_rst_none_extra", 32'(q_in.size()), 32'd0);

        repeat (400) begin
            drive(rand_op(), $urandom_range(0, 9) < 7);
            set_ordy($urandom_range(0, 3) != 0);
            clr_flags = ($urandom_range(0, 9) == 0);
            @(posedge clk); #1;
        end
        drive(mkop(16'h0000, 1'b0, 16'h0000, 1'b0), 1'b0);
        set_ordy(1'b1);
        clr_flags = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("drain_empty", 32'(q_in.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
